// File: rtl/uop_fill_pkg.sv
// Shared types and constants for the uop buffer write side.
// fetched_instruction is one decoded instruction; instruction_bundle pairs two
// of them (i1 in the upper half, i2 in the lower half when flattened).
package uop_fill_pkg;

   localparam int unsigned UOP_BUF_SIZE = 16;
   localparam int unsigned HOLD_TIMEOUT = 4;
   localparam int unsigned INSTR_W      = 32;
   localparam int unsigned BUNDLE_W     = 2 * INSTR_W;

   typedef logic [INSTR_W-1:0] fetched_instruction;

   typedef struct packed {
      fetched_instruction i1;
      fetched_instruction i2;
   } instruction_bundle;

   // Decodes as a no-op (addi x0, x0, 0); pads a bundle that has only one real slot.
   localparam fetched_instruction UOP_NOP = 32'h0000_0013;

   function automatic instruction_bundle make_bundle(input fetched_instruction a,
                                                     input fetched_instruction b);
      instruction_bundle r;
      r.i1 = a;
      r.i2 = b;
      return r;
   endfunction

endpackage

// File: rtl/uop_fill.sv
// uop_fill: pairs decoded instructions into bundles and writes them into the
// circular uop buffer, tracking occupancy against fetch consumption.
// Optional feature: define UOP_FILL_TIMEOUT_EN to flush a held half-bundle
// (padded with UOP_NOP) after HOLD_TIMEOUT cycles without a handshake.
//
// Handshake: an instruction is taken on every rising edge where
// in_valid_i && in_ready_o. in_ready_o depends only on occupancy (count plus
// any write in flight), never on the FSM state, so it carries no path from
// in_valid_i.
module uop_fill
   import uop_fill_pkg::*;
#(
   parameter int unsigned BUF_SIZE = UOP_BUF_SIZE
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear_i,
   input  logic                         in_valid_i,
   input  logic [INSTR_W-1:0]           in_instr_i,
   input  logic                         in_last_i,
   output logic                         in_ready_o,
   input  logic                         rd_advance_i,
   output logic                         wr_en_o,
   output logic [$clog2(BUF_SIZE)-1:0]  wr_addr_o,
   output logic [BUNDLE_W-1:0]          wr_bundle_o,
   output logic [$clog2(BUF_SIZE):0]    count_o,
   output logic                         avail_o,
   output logic                         state_o
);

   localparam int unsigned ADDR_W = $clog2(BUF_SIZE);
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W:0] SIZE_C = (CNT_W+1)'(BUF_SIZE);

   typedef enum logic {
      FILL_IDLE = 1'b0,
      FILL_HOLD = 1'b1
   } fill_state_e;

   fill_state_e         state_q, state_d;
   fetched_instruction  hold_q, hold_d;
   logic                wr_en_q, wr_en_d;
   instruction_bundle   wr_bundle_q, wr_bundle_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [CNT_W:0]      occ;
   logic                space;
   logic                hs;

`ifdef UOP_FILL_TIMEOUT_EN
   localparam int unsigned TMR_W = $clog2(HOLD_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HOLD_TIMEOUT - 1);
   logic [TMR_W-1:0]    timer_q, timer_d;
`endif

   // A write in flight already owns a slot, so it counts against free space.
   assign occ   = {1'b0, count_q} + (CNT_W+1)'(wr_en_q);
   assign space = occ < SIZE_C;
   assign hs    = in_valid_i && space;

   assign in_ready_o  = space;
   assign wr_en_o     = wr_en_q;
   assign wr_addr_o   = wr_addr_q;
   assign wr_bundle_o = wr_bundle_q;
   assign count_o     = count_q;
   assign avail_o     = (count_q != '0);
   assign state_o     = state_q;

   // Pairing FSM: hold the first instruction, emit a bundle on the second or on a last.
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      wr_en_d     = 1'b0;
      wr_bundle_d = wr_bundle_q;
`ifdef UOP_FILL_TIMEOUT_EN
      timer_d     = '0;
`endif
      case (state_q)
         FILL_IDLE: begin
            if (hs) begin
               if (in_last_i) begin
                  wr_en_d     = 1'b1;
                  wr_bundle_d = make_bundle(in_instr_i, UOP_NOP);
               end else begin
                  hold_d  = in_instr_i;
                  state_d = FILL_HOLD;
               end
            end
         end
         FILL_HOLD: begin
            if (hs) begin
               wr_en_d     = 1'b1;
               wr_bundle_d = make_bundle(hold_q, in_instr_i);
               state_d     = FILL_IDLE;
            end
`ifdef UOP_FILL_TIMEOUT_EN
            // Expiry waits for space; the timer saturates meanwhile.
            else if (timer_q >= TMR_LAST) begin
               if (space) begin
                  wr_en_d     = 1'b1;
                  wr_bundle_d = make_bundle(hold_q, UOP_NOP);
                  state_d     = FILL_IDLE;
               end else begin
                  timer_d = timer_q;
               end
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
`endif
         end
         default: state_d = FILL_IDLE;
      endcase
   end

   // Write pointer and occupancy both move on the edge the memory is written.
   always_comb begin
      wr_addr_d = wr_addr_q;
      count_d   = count_q;
      if (wr_en_q) begin
         wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
      if (wr_en_q && !rd_advance_i) begin
         count_d = count_q + CNT_W'(1);
      end else if (rd_advance_i && !wr_en_q && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // State registers; clear behaves exactly like reset and drops any pending write.
   always_ff @(posedge clk) begin
      if (reset || clear_i) begin
         state_q     <= FILL_IDLE;
         hold_q      <= '0;
         wr_en_q     <= 1'b0;
         wr_bundle_q <= '0;
         wr_addr_q   <= '0;
         count_q     <= '0;
`ifdef UOP_FILL_TIMEOUT_EN
         timer_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         wr_en_q     <= wr_en_d;
         wr_bundle_q <= wr_bundle_d;
         wr_addr_q   <= wr_addr_d;
         count_q     <= count_d;
`ifdef UOP_FILL_TIMEOUT_EN
         timer_q     <= timer_d;
`endif
      end
   end

endmodule

// File: tb/tb_uop_fill.sv
// Bench for uop_fill: directed vectors; expected writes go into a queue and a
// negedge monitor pops and compares each write the DUT presents.
module tb_uop_fill;
   import uop_fill_pkg::*;

   localparam int ADDR_W = $clog2(UOP_BUF_SIZE);
   localparam int CNT_W  = ADDR_W + 1;
   localparam int EXP_W  = ADDR_W + BUNDLE_W;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 clear = 1'b0;
   logic                 in_valid = 1'b0;
   logic [INSTR_W-1:0]   in_instr = '0;
   logic                 in_last = 1'b0;
   logic                 in_ready;
   logic                 rd_advance = 1'b0;
   logic                 wr_en;
   logic [ADDR_W-1:0]    wr_addr;
   logic [BUNDLE_W-1:0]  wr_bundle;
   logic [CNT_W-1:0]     count;
   logic                 avail;
   logic                 state;

   int n_cmp = 0;
   int n_err = 0;
   logic [EXP_W-1:0] exp_q[$];
   logic [EXP_W-1:0] mon_e;

   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;
   localparam logic [INSTR_W-1:0] A = 32'hA000_000A;
   localparam logic [INSTR_W-1:0] B = 32'hB000_000B;
   localparam logic [INSTR_W-1:0] C = 32'hC000_000C;

   uop_fill dut (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (clear),
      .in_valid_i   (in_valid),
      .in_instr_i   (in_instr),
      .in_last_i    (in_last),
      .in_ready_o   (in_ready),
      .rd_advance_i (rd_advance),
      .wr_en_o      (wr_en),
      .wr_addr_o    (wr_addr),
      .wr_bundle_o  (wr_bundle),
      .count_o      (count),
      .avail_o      (avail),
      .state_o      (state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input int addr, input logic [INSTR_W-1:0] i1, input logic [INSTR_W-1:0] i2);
      exp_q.push_back({ADDR_W'(addr), i1, i2});
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
      reset = 1'b1; in_valid = 1'b0; rd_advance = 1'b0; clear = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Offer one instruction and hold it until accepted (bounded).
   task automatic send(input logic [INSTR_W-1:0] ins, input logic last);
      int w;
      in_valid = 1'b1; in_instr = ins; in_last = last;
      w = 0;
      while (in_ready !== 1'b1 && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (w >= 200) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: in_ready stuck at %0b, expected 1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Monitor: every presented write must match the head of the expected queue.
   always @(negedge clk) begin
      if (!reset && wr_en === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: addr %0h bundle %0h, expected no write", wr_addr, wr_bundle);
         end else begin
            mon_e = exp_q.pop_front();
            if ({wr_addr, wr_bundle} !== mon_e) begin
               n_err++;
               $display("FAIL write: got addr %0h bundle %0h, expected addr %0h bundle %0h",
                        wr_addr, wr_bundle, mon_e[EXP_W-1 -: ADDR_W], mon_e[BUNDLE_W-1:0]);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      idle(3);
      reset = 1'b0;
      do_reset();

      // Reset state
      check("rst_wr_en", wr_en, 0);
      check("rst_addr", wr_addr, 0);
      check("rst_count", count, 0);
      check("rst_avail", avail, 0);
      check("rst_ready", in_ready, 1);
      check("rst_state", state, 0);
      check("rst_bundle", wr_bundle, 0);

      // rd_advance on an empty buffer is ignored
      rd_advance = 1'b1; idle(1); rd_advance = 1'b0;
      check("empty_adv_count", count, 0);

      // A then B pair into one bundle at address 0
      push(0, A, B);
      send(A, 1'b0);
      check("hold_state", state, 1);
      check("hold_no_write", wr_en, 0);
      send(B, 1'b0);
      check("pair_wr_en", wr_en, 1);
      check("pair_count_before", count, 0);
      check("pair_avail_before", avail, 0);
      idle(1);
      check("pair_count", count, 1);
      check("pair_avail", avail, 1);
      check("pair_addr_next", wr_addr, 1);

      // Single last instruction padded with NOP at address 1
      push(1, C, NOP);
      send(C, 1'b1);
      check("last_state", state, 0);
      idle(1);
      check("last_count", count, 2);
      check("last_addr_next", wr_addr, 2);
      idle(2);

      // Fill the buffer with 32 back-to-back instructions
      do_reset();
      for (int i = 0; i < 16; i++) push(i, 32'h1000 + 2*i, 32'h1000 + 2*i + 1);
      for (int i = 0; i < 32; i++) send(32'h1000 + i, 1'b0);
      check("full_ready_inflight", in_ready, 0);
      idle(1);
      check("full_count", count, 16);
      check("full_ready", in_ready, 0);
      check("full_wrap_addr", wr_addr, 0);
      idle(3);
      check("full_ready_stays", in_ready, 0);
      push(0, 32'h5555_0001, 32'h5555_0002);
      rd_advance = 1'b1; idle(1); rd_advance = 1'b0;
      check("free_count", count, 15);
      check("free_ready", in_ready, 1);
      send(32'h5555_0001, 1'b0);
      send(32'h5555_0002, 1'b0);
      check("refull_ready", in_ready, 0);
      idle(1);
      check("refull_count", count, 16);
      check("refull_addr", wr_addr, 1);
      idle(2);

      // Simultaneous write and rd_advance at count 5
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push(i, 32'h2000 + i, NOP);
         send(32'h2000 + i, 1'b1);
      end
      idle(2);
      check("five_count", count, 5);
      push(5, 32'h2005, NOP);
      send(32'h2005, 1'b1);
      rd_advance = 1'b1; idle(1); rd_advance = 1'b0;
      check("both_count", count, 5);
      check("both_addr", wr_addr, 6);
      rd_advance = 1'b1; idle(1); rd_advance = 1'b0;
      check("adv_count", count, 4);
      idle(2);

      // clear in HOLD together with a handshake: instruction lost
      do_reset();
      send(A, 1'b0);
      check("clr_hold_state", state, 1);
      in_valid = 1'b1; in_instr = B; clear = 1'b1;
      idle(1);
      clear = 1'b0; in_valid = 1'b0;
      check("clr_wr_en", wr_en, 0);
      check("clr_count", count, 0);
      check("clr_state", state, 0);
      check("clr_addr", wr_addr, 0);
      check("clr_ready", in_ready, 1);
      idle(3);

      // clear with a write already registered: occupancy never counts it
      push(0, C, NOP);
      send(C, 1'b1);
      clear = 1'b1;
      idle(1);
      clear = 1'b0;
      check("clr_drop_count", count, 0);
      check("clr_drop_addr", wr_addr, 0);
      check("clr_drop_wr_en", wr_en, 0);
      idle(2);

      // Held instruction with no partner
      do_reset();
`ifdef UOP_FILL_TIMEOUT_EN
      push(0, A, NOP);
      send(A, 1'b0);
      idle(3);
      check("to_not_yet", wr_en, 0);
      check("to_still_hold", state, 1);
      idle(1);
      check("to_flush", wr_en, 1);
      check("to_state", state, 0);
      idle(2);
      check("to_count", count, 1);
`else
      send(A, 1'b0);
      idle(100);
      check("nto_state", state, 1);
      check("nto_count", count, 0);
      check("nto_wr_en", wr_en, 0);
`endif

      idle(2);
      check("queue_final", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
